// File: rtl/parser_collector.sv
// parser_collector
// Return path of the slice distributor. Each one-hot dispatch grant is queued in
// an order FIFO; result beats are then drained only from the parser at the FIFO
// head, so the output stream follows dispatch order even when parsers complete
// out of order.
//
// Ports
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   dispatch_grant      one-hot dispatch from the distributor (0 = no dispatch)
//   order_full          registered stop to the distributor
//   in_valid/in_last    per-parser beat valid and end-of-slice flag
//   in_data             flattened beats, parser i at [i*DATA_W +: DATA_W]
//   in_ready            per-parser accept, only ever the head parser
//   out_valid/out_data/out_last/out_idx/out_ready
//                       registered output beat with source parser index
//   idle                order FIFO empty and no output beat held
//   grant_err           sticky: multi-hot grant or push into a full FIFO
module parser_collector #(
  parameter int NUM_PARSER  = 6,
  parameter int IDX_W       = 3,
  parameter int DATA_W      = 64,
  parameter int ORDER_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PARSER-1:0]        dispatch_grant,
  output logic                         order_full,
  input  logic [NUM_PARSER-1:0]        in_valid,
  input  logic [NUM_PARSER-1:0]        in_last,
  input  logic [NUM_PARSER*DATA_W-1:0] in_data,
  output logic [NUM_PARSER-1:0]        in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_last,
  output logic [IDX_W-1:0]             out_idx,
  input  logic                         out_ready,
  output logic                         idle,
  output logic                         grant_err
);

  localparam int PTR_W = $clog2(ORDER_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // One-hot to binary index of the set bit.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_PARSER-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_PARSER; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

  logic [NUM_PARSER-1:0] order_mem [ORDER_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_next_s;

  logic [NUM_PARSER-1:0] head_s;
  logic                  head_valid_s;
  logic                  out_free_s;
  logic                  accept_s;
  logic                  head_last_s;
  logic                  pop_s;
  logic                  grant_any_s;
  logic                  grant_multi_s;
  logic                  full_s;
  logic                  push_s;
  logic                  err_s;
  logic                  out_valid_next_s;
  logic [DATA_W-1:0]     sel_data_s;

  assign head_s        = order_mem[rd_ptr_r];
  assign head_valid_s  = (count_r != {CNT_W{1'b0}});
  // Output register can take a new beat when empty or being drained this cycle.
  assign out_free_s    = ~out_valid | out_ready;
  assign accept_s      = head_valid_s & (|(head_s & in_valid)) & out_free_s;
  assign head_last_s   = |(head_s & in_last);
  assign pop_s         = accept_s & head_last_s;
  assign in_ready      = head_s & {NUM_PARSER{head_valid_s & out_free_s}};

  // x & (x-1) clears the lowest set bit; anything left means more than one bit.
  assign grant_any_s   = |dispatch_grant;
  assign grant_multi_s = |(dispatch_grant & (dispatch_grant - NUM_PARSER'(1)));
  assign full_s        = (count_r == CNT_W'(ORDER_DEPTH));
  // At full a push is only legal when the head slice retires in the same cycle.
  assign push_s        = grant_any_s & ~grant_multi_s & (~full_s | pop_s);
  assign err_s         = (grant_any_s & grant_multi_s) |
                         (grant_any_s & ~grant_multi_s & full_s & ~pop_s);

  // Head-parser data mux, next count and next output-valid.
  always_comb begin
    sel_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_PARSER; i++) begin
      if (head_s[i]) begin
        sel_data_s = sel_data_s | in_data[i*DATA_W +: DATA_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase

    if (accept_s) begin
      out_valid_next_s = 1'b1;
    end else if (out_ready) begin
      out_valid_next_s = 1'b0;
    end else begin
      out_valid_next_s = out_valid;
    end
  end

  // Order FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      order_mem[wr_ptr_r] <= dispatch_grant;
    end
  end

  // Pointers, count, status flags and the output beat register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      order_full <= 1'b0;
      idle       <= 1'b1;
      grant_err  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= {DATA_W{1'b0}};
      out_last   <= 1'b0;
      out_idx    <= {IDX_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r    <= count_next_s;
      // Asserted one entry early: the distributor's stop is registered and it
      // may still issue one more dispatch.
      order_full <= (count_next_s >= CNT_W'(ORDER_DEPTH - 1));
      idle       <= (count_next_s == {CNT_W{1'b0}}) & ~out_valid_next_s;
      grant_err  <= grant_err | err_s;
      out_valid  <= out_valid_next_s;
      if (accept_s) begin
        out_data <= sel_data_s;
        out_last <= head_last_s;
        out_idx  <= onehot_to_idx(head_s);
      end
    end
  end

endmodule

// File: tb/tb_parser_collector.sv
// Directed testbench for parser_collector: single slice, out-of-order completion,
// backpressure, full/wrap/overflow, reset mid-slice and multi-hot grant.
module tb_parser_collector;

  localparam int NP = 6;
  localparam int DW = 64;

  typedef struct {
    logic [2:0]  idx;
    logic        last;
    logic [63:0] data;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic [NP-1:0]    dispatch_grant;
  logic             order_full;
  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_last;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [2:0]       out_idx;
  logic             out_ready;
  logic             idle;
  logic             grant_err;

  logic [DW-1:0]    drv_data [NP];
  beat_t            pq [NP][$];
  beat_t            exp_q [$];
  int               n_tests;
  int               n_fail;

  parser_collector dut (
    .clk(clk), .rst_n(rst_n), .dispatch_grant(dispatch_grant),
    .order_full(order_full), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_idx(out_idx),
    .out_ready(out_ready), .idle(idle), .grant_err(grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flatten per-parser drive data into the DUT bus.
  always_comb begin
    in_data = '0;
    for (int i = 0; i < NP; i++) in_data[i*DW +: DW] = drv_data[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: present queued parser beats, score the output beat,
  // take the edge, retire accepted parser beats.
  task automatic cyc();
    logic [NP-1:0] acc;
    beat_t e;
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() > 0) begin
        in_valid[p] = 1'b1;
        in_last[p]  = pq[p][0].last;
        drv_data[p] = pq[p][0].data;
      end else begin
        in_valid[p] = 1'b0;
        in_last[p]  = 1'b0;
        drv_data[p] = 64'h0;
      end
    end
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_idx", {61'd0, out_idx}, {61'd0, e.idx});
        check("out_last", {63'd0, out_last}, {63'd0, e.last});
      end
    end
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    dispatch_grant = '0;
    for (int p = 0; p < NP; p++) if (acc[p]) void'(pq[p].pop_front());
  endtask

  // Queue a slice of n beats for parser p and record its expected output.
  task automatic add_slice(input int p, input logic [63:0] base, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.idx  = 3'(p);
      b.last = (i == n - 1);
      b.data = base + 64'(i);
      pq[p].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
      cyc();
      guard++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int plist [17];
    int viol;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    out_ready = 1'b1;
    dispatch_grant = '0;
    in_valid = '0;
    in_last = '0;
    for (int i = 0; i < NP; i++) drv_data[i] = '0;

    // Reset state
    cyc();
    cyc();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_order_full", {63'd0, order_full}, 64'd0);
    check("rst_idle", {63'd0, idle}, 64'd1);
    check("rst_grant_err", {63'd0, grant_err}, 64'd0);
    check("rst_in_ready", {58'd0, in_ready}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_idx", {61'd0, out_idx}, 64'd0);
    rst_n = 1'b1;
    cyc();

    // Single slice on parser 2
    dispatch_grant = 6'b000100;
    cyc();
    check("s1_t1_valid", {63'd0, out_valid}, 64'd0);
    check("s1_t1_ready", {58'd0, in_ready}, 64'b000100);
    add_slice(2, 64'h1111_0000_0000_00A0, 3);
    cyc();
    check("s1_t2_valid", {63'd0, out_valid}, 64'd1);
    check("s1_t2_idx", {61'd0, out_idx}, 64'd2);
    check("s1_t2_last", {63'd0, out_last}, 64'd0);
    cyc();
    check("s1_t3_last", {63'd0, out_last}, 64'd0);
    cyc();
    check("s1_t4_valid", {63'd0, out_valid}, 64'd1);
    check("s1_t4_last", {63'd0, out_last}, 64'd1);
    cyc();
    check("s1_t5_valid", {63'd0, out_valid}, 64'd0);
    check("s1_t5_idle", {63'd0, idle}, 64'd1);

    // Out-of-order completion: parser 1 ready long before parser 0
    dispatch_grant = 6'b000001;
    cyc();
    exp_q.push_back('{idx: 3'd0, last: 1'b0, data: 64'h0000_0000_0000_0A00});
    exp_q.push_back('{idx: 3'd0, last: 1'b1, data: 64'h0000_0000_0000_0A01});
    exp_q.push_back('{idx: 3'd1, last: 1'b1, data: 64'h0000_0000_0000_0B00});
    pq[1].push_back('{idx: 3'd1, last: 1'b1, data: 64'h0000_0000_0000_0B00});
    dispatch_grant = 6'b000010;
    cyc();
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (in_ready[1] || out_valid) viol++;
    end
    check("ooo_hold", 64'(viol), 64'd0);
    check("ooo_head_ready", {58'd0, in_ready}, 64'b000001);
    pq[0].push_back('{idx: 3'd0, last: 1'b0, data: 64'h0000_0000_0000_0A00});
    pq[0].push_back('{idx: 3'd0, last: 1'b1, data: 64'h0000_0000_0000_0A01});
    cyc();
    check("ooo_x1_idx", {61'd0, out_idx}, 64'd0);
    cyc();
    check("ooo_x2_last", {63'd0, out_last}, 64'd1);
    check("ooo_x2_ready", {58'd0, in_ready}, 64'b000010);
    cyc();
    check("ooo_x3_valid", {63'd0, out_valid}, 64'd1);
    check("ooo_x3_idx", {61'd0, out_idx}, 64'd1);
    drain("ooo_drain");

    // Backpressure mid-slice on parser 3
    dispatch_grant = 6'b001000;
    cyc();
    add_slice(3, 64'hDA7A_0000_0000_0000, 6);
    cyc();
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_data", out_data, 64'hDA7A_0000_0000_0001);
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_ready", {58'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    drain("bp_drain");
    check("bp_pq_empty", 64'(pq[3].size()), 64'd0);

    // Full, push+pop at full, overflow, then drain across the wrap
    for (int k = 0; k < 17; k++) plist[k] = (k * 5 + 1) % 6;
    for (int k = 0; k < 16; k++) begin
      dispatch_grant = 6'(1 << plist[k]);
      cyc();
      if (k == 13) check("full_at14", {63'd0, order_full}, 64'd0);
      if (k == 14) check("full_at15", {63'd0, order_full}, 64'd1);
    end
    check("full16_err", {63'd0, grant_err}, 64'd0);
    check("full16_idle", {63'd0, idle}, 64'd0);
    pq[plist[0]].push_back('{idx: 3'(plist[0]), last: 1'b1, data: 64'hA000});
    exp_q.push_back('{idx: 3'(plist[0]), last: 1'b1, data: 64'hA000});
    dispatch_grant = 6'(1 << plist[16]);
    cyc();
    check("pushpop_full_err", {63'd0, grant_err}, 64'd0);
    dispatch_grant = 6'b000001;
    cyc();
    check("overflow_err", {63'd0, grant_err}, 64'd1);
    check("overflow_full", {63'd0, order_full}, 64'd1);
    for (int k = 1; k < 17; k++) begin
      pq[plist[k]].push_back('{idx: 3'(plist[k]), last: 1'b1, data: 64'hA000 + 64'(k)});
      exp_q.push_back('{idx: 3'(plist[k]), last: 1'b1, data: 64'hA000 + 64'(k)});
    end
    drain("wrap_drain");
    cyc();
    check("wrap_idle", {63'd0, idle}, 64'd1);
    check("wrap_full", {63'd0, order_full}, 64'd0);

    // Reset mid-slice with 4 entries queued and an output beat held
    out_ready = 1'b0;
    dispatch_grant = 6'b000001;
    cyc();
    pq[0].push_back('{idx: 3'd0, last: 1'b0, data: 64'h5555});
    for (int p = 1; p < 4; p++) begin
      dispatch_grant = 6'(1 << p);
      cyc();
    end
    check("mid_valid", {63'd0, out_valid}, 64'd1);
    check("mid_full", {63'd0, order_full}, 64'd0);
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) pq[p].delete();
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_full", {63'd0, order_full}, 64'd0);
    check("mrst_idle", {63'd0, idle}, 64'd1);
    check("mrst_err", {63'd0, grant_err}, 64'd0);
    check("mrst_ready", {58'd0, in_ready}, 64'd0);

    // Multi-hot grant
    dispatch_grant = 6'b000011;
    cyc();
    check("multi_err", {63'd0, grant_err}, 64'd1);
    check("multi_idle", {63'd0, idle}, 64'd1);
    cyc();
    check("multi_sticky", {63'd0, grant_err}, 64'd1);
    check("multi_ready", {58'd0, in_ready}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
